// File: rtl/add_arb_pkg.sv
// Shared state encoding, default operand width and iteration-count width helper
// for the iterative-add arbiter.
package add_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned ADD_ARB_N = 8;

  // Worst-case iteration count is N+1, so the counter must hold 0..N+1.
  function automatic int unsigned iter_w(input int unsigned n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/add_iter_dp.sv
// A/B iteration registers: A <= A^B, B <= (A&B)<<1 each step until B drains to zero.
// One step per cycle; load takes priority over step, no backpressure of its own.
module add_iter_dp
  import add_arb_pkg::*;
#(
  parameter int unsigned W = ADD_ARB_N + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_a,
  output logic         o_b_zero
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_load) begin
      r_a <= i_a;
      r_b <= i_b;
    end else if (i_step) begin
      r_a <= r_a ^ r_b;
      // Carry moves up one bit; anything shifted past bit W-1 cannot exist with zero-extended operands.
      r_b <= (r_a & r_b) << 1;
    end
  end

  assign o_a      = r_a;
  assign o_b_zero = (r_b == '0);

endmodule

// File: rtl/add_iter_arbiter.sv
// Round-robin two-requester front end for an iterative adder; valid_o strobes k+2 cycles after grant.
// Requests are ignored while busy; define ADD_ITER_CNT_EN to add iter_o reporting k with each result.
module add_iter_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned N = ADD_ARB_N
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic [N-1:0]          a0_i,
  input  logic [N-1:0]          b0_i,
  input  logic [N-1:0]          a1_i,
  input  logic [N-1:0]          b1_i,
  output logic [1:0]            gnt_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [N:0]            sum_o,
`ifdef ADD_ITER_CNT_EN
  output logic [iter_w(N)-1:0]  iter_o,
`endif
  output logic                  id_o
);

  state_t     r_state;
  logic       r_ptr;
  logic       r_cur_id;
  logic       r_valid;
  logic       r_id;
  logic [N:0] r_sum;

  logic       w_win;
  logic       w_accept;
  logic       w_step;
  logic       w_b_zero;
  logic [N:0] w_a_ext;
  logic [N:0] w_b_ext;
  logic [N:0] w_acc;

`ifdef ADD_ITER_CNT_EN
  localparam int unsigned IW = iter_w(N);
  localparam logic [IW-1:0] ITER_ONE = IW'(1);
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] r_iter;
  assign iter_o = r_iter;
`endif

  // Pointer only breaks ties; a lone requester always wins.
  assign w_win    = (req0_i & req1_i) ? r_ptr : req1_i;
  assign w_accept = ~rst_i & (r_state == IDLE) & (req0_i | req1_i);
  assign w_step   = (r_state == RUN) & ~w_b_zero;
  assign gnt_o    = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign w_a_ext  = {1'b0, (w_win ? a1_i : a0_i)};
  assign w_b_ext  = {1'b0, (w_win ? b1_i : b0_i)};

  add_iter_dp #(
    .W (N + 1)
  ) u_dp (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_a      (w_a_ext),
    .i_b      (w_b_ext),
    .o_a      (w_acc),
    .o_b_zero (w_b_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_cur_id <= 1'b0;
      r_valid  <= 1'b0;
      r_id     <= 1'b0;
      r_sum    <= '0;
`ifdef ADD_ITER_CNT_EN
      r_cnt    <= '0;
      r_iter   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_state  <= RUN;
          r_cur_id <= w_win;
          r_ptr    <= ~w_win;
`ifdef ADD_ITER_CNT_EN
          r_cnt    <= '0;
`endif
        end
      end else if (w_b_zero) begin
        r_state <= IDLE;
        r_sum   <= w_acc;
        r_id    <= r_cur_id;
        r_valid <= 1'b1;
`ifdef ADD_ITER_CNT_EN
        r_iter  <= r_cnt;
`endif
      end else begin
`ifdef ADD_ITER_CNT_EN
        r_cnt <= r_cnt + ITER_ONE;
`endif
      end
    end
  end

  assign busy_o  = (r_state == RUN);
  assign valid_o = r_valid;
  assign sum_o   = r_sum;
  assign id_o    = r_id;

endmodule

// File: tb/tb_add_iter_arbiter.sv
// Scoreboard bench for add_iter_arbiter: per-cycle grant/busy prediction by a round-robin model,
// results checked against a+b, the owning id and the k+2 cycle latency.
module tb_add_iter_arbiter;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req0_i, req1_i;
  logic [N-1:0] a0_i, b0_i, a1_i, b1_i;
  logic [1:0]   gnt_o;
  logic         busy_o, valid_o, id_o;
  logic [N:0]   sum_o;
`ifdef ADD_ITER_CNT_EN
  logic [$clog2(N+2)-1:0] iter_o;
`endif

  add_iter_arbiter #(.N(N)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req0_i  (req0_i),
    .req1_i  (req1_i),
    .a0_i    (a0_i),
    .b0_i    (b0_i),
    .a1_i    (a1_i),
    .b1_i    (b1_i),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .sum_o   (sum_o),
`ifdef ADD_ITER_CNT_EN
    .iter_o  (iter_o),
`endif
    .id_o    (id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } op_t;

  typedef struct {
    int         id;
    logic [N:0] sum;
    int         k;
    int         gcyc;
  } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  int m_free = 0;
  bit pop0   = 0;
  bit pop1   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Number of carry-propagation rounds until no carry remains, taken on N+1-bit values.
  function automatic int ref_iters(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s, c, t;
    int k;
    s = {1'b0, a};
    c = {1'b0, b};
    k = 0;
    while (c != 0 && k < 64) begin
      t = s ^ c;
      c = (s & c) << 1;
      s = t;
      k++;
    end
    return k;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    case ($urandom_range(0, 4))
      0:       o.a = '0;
      1:       o.a = '1;
      default: o.a = N'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0:       o.b = '0;
      1:       o.b = N'(1);
      default: o.b = N'($urandom);
    endcase
    return o;
  endfunction

  task automatic push(input int who, input logic [N-1:0] a, input logic [N-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    if (who == 1) q1.push_back(o);
    else          q0.push_back(o);
  endtask

  task automatic drive();
    req0_i = (q0.size() != 0);
    req1_i = (q1.size() != 0);
    if (q0.size() != 0) begin a0_i = q0[0].a; b0_i = q0[0].b; end
    if (q1.size() != 0) begin a1_i = q1[0].a; b1_i = q1[0].b; end
  endtask

  // One clock: retire last grant, present requests, then predict and check grant/busy.
  task automatic step();
    int   win;
    logic [1:0] eg;
    logic eb;
    op_t  o;
    exp_t e;
    @(posedge clk_i);
    #1;
    if (pop0) begin q0.delete(0); pop0 = 0; end
    if (pop1) begin q1.delete(0); pop1 = 0; end
    drive();
    @(negedge clk_i);
    eb  = (cyc < m_free);
    eg  = 2'b00;
    win = 0;
    if (!eb && (q0.size() != 0 || q1.size() != 0)) begin
      win = (q0.size() != 0 && q1.size() != 0) ? m_ptr : ((q1.size() != 0) ? 1 : 0);
      eg  = (win == 1) ? 2'b10 : 2'b01;
    end
    chk("busy", busy_o, eb);
    chk("gnt", gnt_o, eg);
    if (eg != 2'b00) begin
      o      = (win == 1) ? q1[0] : q0[0];
      e.id   = win;
      e.sum  = (N+1)'(o.a) + (N+1)'(o.b);
      e.k    = ref_iters(o.a, o.b);
      e.gcyc = cyc;
      sb.push_back(e);
      m_ptr  = 1 - win;
      m_free = cyc + e.k + 2;
      if (win == 1) pop1 = 1;
      else          pop0 = 1;
    end
  endtask

  task automatic run();
    int n = 0;
    while (q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || pop0 || pop1 || cyc < m_free) begin
      if (n >= 400) begin
        checks++;
        errors++;
        $display("FAIL run_timeout at cycle %0d: %0d results still outstanding, expected 0", cyc, sb.size());
        q0.delete(); q1.delete(); sb.delete();
        pop0 = 0; pop1 = 0; m_free = 0;
        break;
      end
      step();
      n++;
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at cycle %0d: got id %0d sum %0d, expected no result", cyc, id_o, sum_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", sum_o, e.sum);
        chk("id", id_o, e.id);
        chk("latency", cyc - e.gcyc, e.k + 2);
`ifdef ADD_ITER_CNT_EN
        chk("iter", iter_o, e.k);
`endif
      end
    end
  end

  initial begin
    req0_i = 1'b1; req1_i = 1'b0;
    a0_i = 8'd3; b0_i = 8'd4; a1_i = '0; b1_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_id", id_o, 0);
`ifdef ADD_ITER_CNT_EN
    chk("rst_iter", iter_o, 0);
`endif
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    drive();

    push(0, 8'd1, 8'd1);     run();
    push(0, 8'd0, 8'd0);     run();
    push(0, 8'hFF, 8'h01);   run();
    push(1, 8'd5, 8'd5);     run();

    // Both held for three transactions.
    push(0, 8'd10, 8'd20);
    push(0, 8'd200, 8'd100);
    push(1, 8'd7, 8'd9);
    run();

    // Requester 1 arrives mid-operation and must wait for the valid cycle.
    push(0, 8'hFF, 8'h01);
    repeat (3) step();
    push(1, 8'h12, 8'h34);
    run();

    // Abort a long addition with a one-cycle reset.
    push(0, 8'hFF, 8'h01);
    repeat (3) step();
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    sb.delete();
    pop0 = 0; pop1 = 0;
    m_ptr = 0; m_free = 0;
    @(negedge clk_i);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_sum", sum_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    drive();
    repeat (12) step();
    push(0, 8'd3, 8'd4);
    push(1, 8'd5, 8'd6);
    run();

    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r[0] || r == 0) push(0, rand_op().a, rand_op().b);
      if (r[1]) push(1, rand_op().a, rand_op().b);
      if ($urandom_range(0, 2) == 0) push(r[0] ? 1 : 0, rand_op().a, rand_op().b);
      run();
    end

    repeat (5) step();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_iter_arbiter.md
ADD_ITER_ARBITER -- requirements
Module: add_iter_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: operand width in bits.
REQ-002 SHALL have port clk_i  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have ports req0_i, req1_i  input  1 each: requester 0/1 holds request high with operands stable until granted.
REQ-005 SHALL have ports a0_i, b0_i, a1_i, b1_i  input  N each: operands of requester 0/1.
REQ-006 SHALL have port gnt_o  output  2: one-hot grant, combinational, high only in the accept cycle.
REQ-007 SHALL have port busy_o  output  1: high while an addition is in progress.
REQ-008 SHALL have port valid_o  output  1: registered one-cycle result strobe.
REQ-009 SHALL have port sum_o  output  N+1: result, zero-extended operands, carry in MSB; held until the next valid_o.
REQ-010 SHALL have port id_o  output  1: index of the requester owning sum_o.

Function
REQ-011 SHALL implement states IDLE and RUN.
REQ-012 IDLE with any request: assert gnt_o for the winner; capture {0,a}, {0,b} into internal registers A, B (N+1 bits); record id; go to RUN.
REQ-013 Arbitration SHALL be round-robin: both requesting -> grant the requester selected by the priority pointer; after every grant the pointer moves to the other requester.
REQ-014 RUN with B != 0: A <= A xor B; B <= (A and B) << 1, truncated to N+1 bits; stay in RUN.
REQ-015 RUN with B == 0: sum_o <= A; id_o <= recorded id; valid_o <= 1 for exactly one cycle; go to IDLE.
REQ-016 Latency: valid_o SHALL be high exactly k+2 cycles after the grant cycle, where k is the number of RUN iterations with B != 0; k <= N+1, so the worst case is N+3.
REQ-017 Requests during RUN SHALL be ignored: gnt_o = 0 and no operand capture.
REQ-018 The cycle in which valid_o is high is in IDLE and SHALL permit a new grant, giving back-to-back operation.
REQ-019 busy_o SHALL equal (state == RUN).
REQ-020 No overflow SHALL be possible; the full N+1-bit sum is always returned.

Reset
REQ-021 While rst_i is high: state = IDLE; A, B, sum_o = 0; valid_o = 0; id_o = 0; pointer selects requester 0; gnt_o = 0.
REQ-022 Reset during RUN SHALL abort the operation with no valid_o and no result update.

Configuration
REQ-023 When ADD_ITER_CNT_EN is defined, the block SHALL add output iter_o (width clog2(N+2)), registered with sum_o, holding k of that result; reset value 0.
REQ-024 When ADD_ITER_CNT_EN is undefined, iter_o and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package add_arb_pkg SHALL hold the state enum (IDLE, RUN) and the default width constant.
REQ-026 The A/B iteration registers and their B == 0 detect SHALL be in sub-module add_iter_dp; the FSM and arbiter SHALL be in add_iter_arbiter.

Verification
REQ-027 N=8, req0 with a0=1, b0=1 -> gnt_o=01; valid_o 4 cycles later; sum_o=2; id_o=0; iter_o=2.
REQ-028 a0=0, b0=0 -> valid_o 2 cycles after grant; sum_o=0; iter_o=0.
REQ-029 a0=8'hFF, b0=8'h01 -> valid_o after N+3=11 cycles; sum_o=9'h100; iter_o=9.
REQ-030 req0 and req1 high together, held for three transactions -> grant order 0, 1, 0; each valid_o carries the matching id_o and sum.
REQ-031 rst_i asserted for 1 cycle mid-RUN of 255+1 -> no valid_o; state IDLE; next request granted to requester 0.
REQ-032 req1 asserted during RUN and held -> gnt_o=00 until the valid_o cycle; gnt_o=10 in that same cycle.
